shift_unit_arbiter: RTL and testbench

- Shares the single-cycle combinational barrel shifter between two requesters: requester 0 is the main ALU shift path, requester 1 is the secondary/multi-cycle unit.
- Arbitrates round-robin, latches the winning operation and drives the shifter from registers.
- Captures the result and returns it on the winner's response channel with a valid/ready handshake.
- Sits between the execute-stage requesters and the shifter instance.

---
 rtl/shift_unit_arbiter_if.sv | 50 +++++
 rtl/shift_unit_arbiter.sv | 103 ++++++++++
 tb/tb_shift_unit_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_unit_arbiter_if.sv
// Bundle of requester, response and shifter-side signals around the shift unit arbiter.
// The arbiter takes the slave view; the execute stage and shifter share the master view.
interface shift_unit_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data;
  logic [SH_W-1:0]   req0_shamt;
  logic              req0_right;
  logic              req0_arith;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data;
  logic [SH_W-1:0]   req1_shamt;
  logic              req1_right;
  logic              req1_arith;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;

  logic [DATA_W-1:0] sh_orig;
  logic [SH_W-1:0]   sh_index;
  logic              sh_right;
  logic              sh_arith;
  logic [DATA_W-1:0] sh_result;

  modport slave (
    input  req0_valid, req0_data, req0_shamt, req0_right, req0_arith, rsp0_ready,
    input  req1_valid, req1_data, req1_shamt, req1_right, req1_arith, rsp1_ready,
    input  sh_result,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output sh_orig, sh_index, sh_right, sh_arith
  );

  modport master (
    output req0_valid, req0_data, req0_shamt, req0_right, req0_arith, rsp0_ready,
    output req1_valid, req1_data, req1_shamt, req1_right, req1_arith, rsp1_ready,
    output sh_result,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  sh_orig, sh_index, sh_right, sh_arith
  );
endinterface

// File: rtl/shift_unit_arbiter.sv
// Round-robin arbiter sharing one combinational barrel shifter between two requesters.
// Each operation runs IDLE -> EXEC -> RESP; the shifter is always driven from registers.
module shift_unit_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned SH_W   = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  shift_unit_arbiter_if.slave   bus,
  output logic                  o_busy
);

  if (SH_W != $clog2(DATA_W)) begin : g_bad_sh_w
    $error("SH_W must equal log2(DATA_W)");
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            r_state;
  logic              r_last_grant;
  logic              r_owner;
  logic [DATA_W-1:0] r_data;
  logic [SH_W-1:0]   r_shamt;
  logic              r_right;
  logic              r_arith;
  logic [DATA_W-1:0] r_rsp_data;
  logic              r_rsp0_valid;
  logic              r_rsp1_valid;
  logic              r_busy;

  logic w_idle;
  logic w_gnt0;
  logic w_gnt1;
  logic w_rsp_hs;

  // On a tie the requester that did not win last time gets the grant.
  assign w_idle   = (r_state == StIdle);
  assign w_gnt0   = bus.req0_valid & (~bus.req1_valid | r_last_grant);
  assign w_gnt1   = bus.req1_valid & (~bus.req0_valid | ~r_last_grant);
  assign w_rsp_hs = r_owner ? (r_rsp1_valid & bus.rsp1_ready) : (r_rsp0_valid & bus.rsp0_ready);

  assign bus.req0_ready = w_idle & w_gnt0;
  assign bus.req1_ready = w_idle & w_gnt1;
  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp0_data  = r_rsp_data;
  assign bus.rsp1_data  = r_rsp_data;
  assign bus.sh_orig    = r_data;
  assign bus.sh_index   = r_shamt;
  assign bus.sh_right   = r_right;
  assign bus.sh_arith   = r_arith;
  assign o_busy         = r_busy;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_owner      <= 1'b0;
      r_data       <= '0;
      r_shamt      <= '0;
      r_right      <= 1'b0;
      r_arith      <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt0 | w_gnt1) begin
            r_owner <= w_gnt1;
            r_data  <= w_gnt1 ? bus.req1_data  : bus.req0_data;
            r_shamt <= w_gnt1 ? bus.req1_shamt : bus.req0_shamt;
            r_right <= w_gnt1 ? bus.req1_right : bus.req0_right;
            r_arith <= w_gnt1 ? bus.req1_arith : bus.req0_arith;
            r_state <= StExec;
            r_busy  <= 1'b1;
          end
        end
        StExec: begin
          r_rsp_data   <= bus.sh_result;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <= r_owner;
          r_state      <= StResp;
        end
        StResp: begin
          if (w_rsp_hs) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_last_grant <= r_owner;
            r_state      <= StIdle;
            r_busy       <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed self-checking bench for shift_unit_arbiter with a behavioural shifter attached.
module tb_shift_unit_arbiter;

  logic clk;
  logic rstn;
  logic busy;
  int   n_checks;
  int   n_errors;

  shift_unit_arbiter_if #(.DATA_W(32), .SH_W(5)) bus ();

  shift_unit_arbiter #(.DATA_W(32), .SH_W(5)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus.slave),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.sh_result = !bus.sh_right ? (bus.sh_orig << bus.sh_index) :
                         bus.sh_arith  ? 32'($signed(bus.sh_orig) >>> bus.sh_index) :
                                         (bus.sh_orig >> bus.sh_index);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.req0_valid = 1'b0; bus.req0_data = '0; bus.req0_shamt = '0;
    bus.req0_right = 1'b0; bus.req0_arith = 1'b0; bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_data = '0; bus.req1_shamt = '0;
    bus.req1_right = 1'b0; bus.req1_arith = 1'b0; bus.rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // One full operation from a single requester, checking handshake timing and the result.
  task automatic single_op(input int idx, input logic [31:0] data, input logic [4:0] shamt,
                           input logic right, input logic arith, input logic [31:0] exp,
                           input string name);
    logic rdy_me, rdy_other, v_me, v_other;
    logic [31:0] d_me;
    if (idx == 0) begin
      bus.req0_valid = 1'b1; bus.req0_data = data; bus.req0_shamt = shamt;
      bus.req0_right = right; bus.req0_arith = arith;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_data = data; bus.req1_shamt = shamt;
      bus.req1_right = right; bus.req1_arith = arith;
    end
    #1;
    rdy_me    = (idx == 0) ? bus.req0_ready : bus.req1_ready;
    rdy_other = (idx == 0) ? bus.req1_ready : bus.req0_ready;
    n_checks++;
    if ({rdy_me, rdy_other} !== 2'b10) begin
      n_errors++;
      $display("FAIL %s ready: got %b expected 10", name, {rdy_me, rdy_other});
    end
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL %s exec: busy/rsp0v/rsp1v got %b expected 100", name,
               {busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    tick();
    v_me    = (idx == 0) ? bus.rsp0_valid : bus.rsp1_valid;
    v_other = (idx == 0) ? bus.rsp1_valid : bus.rsp0_valid;
    d_me    = (idx == 0) ? bus.rsp0_data  : bus.rsp1_data;
    n_checks++;
    if ({v_me, v_other} !== 2'b10) begin
      n_errors++;
      $display("FAIL %s rsp_valid: got %b expected 10", name, {v_me, v_other});
    end
    n_checks++;
    if (d_me !== exp) begin
      n_errors++;
      $display("FAIL %s rsp_data: got %h expected %h", name, d_me, exp);
    end
    if (idx == 0) bus.rsp0_ready = 1'b1;
    else          bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL %s done: busy/rsp0v/rsp1v got %b expected 000", name,
               {busy, bus.rsp0_valid, bus.rsp1_valid});
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags: got %b expected 000", {busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    n_checks++;
    if ({bus.sh_orig, bus.sh_index, bus.sh_right, bus.sh_arith} !== 39'd0) begin
      n_errors++;
      $display("FAIL reset_sh: got %h expected 0",
               {bus.sh_orig, bus.sh_index, bus.sh_right, bus.sh_arith});
    end
    n_checks++;
    if ({bus.rsp0_data, bus.rsp1_data} !== 64'd0) begin
      n_errors++;
      $display("FAIL reset_rsp_data: got %h expected 0", {bus.rsp0_data, bus.rsp1_data});
    end
  endtask

  task automatic test_req0_only();
    single_op(0, 32'h0000_00F0, 5'd4, 1'b0, 1'b0, 32'h0000_0F00, "req0_left");
  endtask

  task automatic test_req1_right();
    single_op(1, 32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF, "req1_arith");
    single_op(1, 32'h8000_0000, 5'd31, 1'b1, 1'b0, 32'h0000_0001, "req1_logic");
  endtask

  task automatic test_edge_shifts();
    single_op(0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'hDEAD_BEEF, "zero_left");
    single_op(1, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, "zero_lsr");
    single_op(0, 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, "zero_asr");
    single_op(1, 32'hC000_0001, 5'd1, 1'b0, 1'b1, 32'h8000_0002, "left_arith");
  endtask

  task automatic test_fairness();
    logic [31:0] exp;
    int          own;
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_0001; bus.req0_shamt = 5'd1;
    bus.req0_right = 1'b0; bus.req0_arith = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 32'h0000_0100; bus.req1_shamt = 5'd4;
    bus.req1_right = 1'b1; bus.req1_arith = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      own = k % 2;
      exp = (own == 0) ? 32'h0000_0002 : 32'h0000_0010;
      n_checks++;
      if ({bus.req0_ready, bus.req1_ready} !== ((own == 0) ? 2'b10 : 2'b01)) begin
        n_errors++;
        $display("FAIL rr_grant%0d: got %b expected owner %0d", k,
                 {bus.req0_ready, bus.req1_ready}, own);
      end
      tick();
      tick();
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== ((own == 0) ? 2'b10 : 2'b01)) begin
        n_errors++;
        $display("FAIL rr_rsp%0d: got %b expected owner %0d", k,
                 {bus.rsp0_valid, bus.rsp1_valid}, own);
      end
      n_checks++;
      if (((own == 0) ? bus.rsp0_data : bus.rsp1_data) !== exp) begin
        n_errors++;
        $display("FAIL rr_data%0d: got %h expected %h", k,
                 (own == 0) ? bus.rsp0_data : bus.rsp1_data, exp);
      end
      tick();
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_backpressure();
    // Last grant is requester 1, so a lone req0 is taken first.
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_0003; bus.req0_shamt = 5'd2;
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 32'h0000_00F0; bus.req1_shamt = 5'd4;
    bus.req1_right = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if ({bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, busy} !== 4'b1001 ||
          bus.rsp0_data !== 32'h0000_000C) begin
        n_errors++;
        $display("FAIL bp_hold%0d: v0/v1/rdy1/busy %b data %h expected 1001 0000000c", c,
                 {bus.rsp0_valid, bus.rsp1_valid, bus.req1_ready, busy}, bus.rsp0_data);
      end
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_no_bypass: req1_ready got %b expected 0", bus.req1_ready);
    end
    tick();
    bus.rsp0_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.req1_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_regrant: req1_ready got %b expected 1", bus.req1_ready);
    end
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.rsp1_valid !== 1'b1 || bus.rsp1_data !== 32'h0000_000F) begin
      n_errors++;
      $display("FAIL bp_req1_rsp: valid %b data %h expected 1 0000000f",
               bus.rsp1_valid, bus.rsp1_data);
    end
    bus.rsp1_ready = 1'b1;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset_midop();
    bus.req0_valid = 1'b1; bus.req0_data = 32'h0000_0011; bus.req0_shamt = 5'd1;
    tick();
    bus.req0_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_exec: busy/v0/v1 got %b expected 000",
               {busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    tick();
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000) begin
      n_errors++;
      $display("FAIL rst_exec_after: busy/v0/v1 got %b expected 000",
               {busy, bus.rsp0_valid, bus.rsp1_valid});
    end
    bus.rsp0_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_data = 32'h0000_0022; bus.req1_shamt = 5'd1;
    tick();
    bus.req1_valid = 1'b0;
    tick();
    n_checks++;
    if (bus.rsp1_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_pre_resp: rsp1_valid got %b expected 1", bus.rsp1_valid);
    end
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    n_checks++;
    if ({busy, bus.rsp0_valid, bus.rsp1_valid} !== 3'b000 || bus.rsp1_data !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_resp: busy/v0/v1 %b data %h expected 000 00000000",
               {busy, bus.rsp0_valid, bus.rsp1_valid}, bus.rsp1_data);
    end
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    #1;
    n_checks++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_errors++;
      $display("FAIL rst_first_grant: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    clear_inputs();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rstn     = 1'b1;
    test_reset();
    test_req0_only();
    test_req1_right();
    test_edge_shifts();
    test_fairness();
    test_backpressure();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
